vespa_int_ctrl: RTL and testbench
=================================

Name: vespa_int_ctrl

Overview:
- Interrupt controller driving the VeSPA CPU interrupt interface (int_req, int_number, int_ack_attended, int_ack_complete) from four peripheral IRQ lines.
- Edge-detects and latches requests, applies a software mask, and presents one prioritised request at a time.
- Tracks the handshake through attend and complete; no nesting: one interrupt in service at a time.

Parameters:
- NUM_SRC, 4, number of IRQ sources; fixed at 4 to match the 2-bit int_number (other values unsupported).
- RST_MASK, 4'b0000, mask register value after reset (1 = source enabled).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- irq_in  input  4  peripheral request lines; active-high, rising-edge sensitive
- mask_we  input  1  mask register write strobe
- mask_data  input  4  new mask value, loaded when mask_we=1
- int_req  output  1  interrupt request to CPU
- int_number  output  2  vector of the requested source; valid while int_req=1 and throughout service
- int_ack_attended  input  1  CPU single-cycle pulse: vector taken, ISR entered
- int_ack_complete  input  1  CPU single-cycle pulse: return-from-interrupt executed
- pending  output  4  latched, not-yet-attended requests (status)
- in_service  output  4  one-hot source currently being serviced, 0 if none

Behaviour:
- Reset (rst=0, async): pending=0, in_service=0, int_req=0, int_number=0, mask=RST_MASK, irq_in previous-sample register=0, FSM=IDLE.
- Edge detect: irq_in sampled each clock; bit i is a rising edge when it is 1 and the previous sample was 0.
  - A rising edge sets pending[i] at that clock edge, regardless of mask.
  - Level held high does not re-trigger.
- Mask: on mask_we, mask<=mask_data at the clock edge. Masked pending bits stay latched and become eligible once unmasked.
- Eligible set = pending & mask. Priority: lowest index wins (source 0 highest).
- FSM states:
  - IDLE: if the eligible set is non-zero, go to REQ, register int_req=1 and int_number=winner. int_req rises one clock after the pending bit is visible.
  - REQ: int_req=1 and int_number are frozen. New edges and mask changes do not alter the vector, and masking the requested source does not withdraw it. On int_ack_attended: clear pending[int_number], set in_service to one-hot(int_number), int_req<=0, go to SERVICE.
  - SERVICE: int_req=0, int_number held. Pending bits continue to accumulate. On int_ack_complete: in_service<=0, go to IDLE. A new request may be raised from the next cycle.
- Latency: irq_in edge sampled at clock k -> pending set after k -> int_req=1 after clock k+1. Minimum gap from complete to next int_req is 2 clocks (IDLE evaluation cycle).
- Boundary conditions:
  - New rising edge on source i in the same cycle pending[i] is cleared by attend: the set wins, pending[i] stays 1.
  - int_ack_complete in IDLE or REQ: ignored.
  - int_ack_attended in IDLE or SERVICE: ignored.
  - Attend and complete in the same cycle in REQ: attend taken, complete ignored.
  - mask_we in the same cycle as the IDLE decision: the decision uses the old mask.
  - Reset mid-handshake: everything returns to reset values immediately and the CPU sees int_req drop asynchronously.

Optional Feature:
- Macro: INT_CTRL_SYNC_EN.
- Defined: irq_in passes through a 2-flop synchroniser per bit before edge detection. Edge-to-pending latency grows by 2 clocks (int_req after clock k+3). Synchroniser flops reset to 0.
- Undefined: irq_in is assumed synchronous to clk and feeds edge detection directly.

Test Plan:
- Reset with mask_data=4'b1111 written; pulse irq_in[2] -> pending=4'b0100, int_req=1 with int_number=2 one clock later; attend pulse -> pending=0, in_service=4'b0100, int_req=0; complete -> in_service=0.
- Edges on irq_in[3] and irq_in[1] in the same cycle, mask=1111 -> int_number=1 first; after attend and complete, int_number=3 raised 2 clocks after complete.
- mask=4'b1110, edge on irq_in[0] -> pending=0001, int_req stays 0 for 20 cycles; write mask=1111 -> int_req=1, int_number=0.
- During SERVICE of source 2, edge on irq_in[0] -> int_req stays 0 until complete, then int_number=0; complete pulse in IDLE -> no state change.
- Edge on irq_in[1] in the same cycle as attend for source 1 -> pending[1] remains 1 and source 1 is re-requested after complete.
- Assert rst=0 while in REQ -> int_req, pending, in_service go to 0 before the next clock edge; with INT_CTRL_SYNC_EN defined, edge-to-int_req latency measures 4 clocks versus 2 without.

Source files
------------

// File: rtl/vespa_int_ctrl.sv
// ---------------------------------------------------------------------------
// vespa_int_ctrl
// Interrupt controller for the VeSPA CPU interrupt interface. Four
// peripheral IRQ lines are edge-detected and latched into a pending
// register. A software mask selects which pending sources are eligible.
// One prioritised request (lowest index wins) is presented to the CPU and
// tracked through the attend/complete handshake. Only one interrupt is in
// service at a time, so there is no nesting.
//
// Build option:
//   INT_CTRL_SYNC_EN - when defined, each irq_in bit passes through a
//                      2-flop synchroniser before edge detection. This adds
//                      two clocks of edge-to-pending latency. When it is
//                      undefined, irq_in is taken as synchronous to clk.
// ---------------------------------------------------------------------------
module vespa_int_ctrl #(
  // Fixed at 4 to match the 2-bit int_number. Other values are unsupported.
  parameter int                 NUM_SRC  = 4,
  // Mask value after reset. A 1 bit enables that source.
  parameter logic [NUM_SRC-1:0] RST_MASK = 4'b0000
) (
  input  logic               clk,
  input  logic               rst,               // async, active-low
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_data,
  output logic               int_req,
  output logic [1:0]         int_number,
  input  logic               int_ack_attended,
  input  logic               int_ack_complete,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e             state_q;
  logic               int_req_q;
  logic [1:0]         int_number_q;
  logic [NUM_SRC-1:0] in_service_q;

  logic [NUM_SRC-1:0] irq_s;
  logic [NUM_SRC-1:0] irq_prev_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] eligible;
  logic               winner_valid;
  logic [1:0]         winner_idx;
  logic               attend_take;
  logic [NUM_SRC-1:0] number_onehot;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
`ifdef INT_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q;
  logic [NUM_SRC-1:0] sync2_q;

  // Two-flop synchroniser per bit, used when irq_in is asynchronous to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2_q take the old sync1_q.
      // With blocking assignments the two flops would collapse into one.
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  // Keep the previous sample of the conditioned IRQ lines for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_prev_q <= '0;
    else      irq_prev_q <= irq_s;
  end

  // A bit is a rising edge when it is high now and was low last sample.
  // A level held high therefore does not re-trigger.
  assign rise = irq_s & ~irq_prev_q;

  // -------------------------------------------------------------------------
  // Software mask
  // -------------------------------------------------------------------------
  // Load the mask register when mask_we is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         mask_q <= RST_MASK;
    else if (mask_we) mask_q <= mask_data;
  end

  // -------------------------------------------------------------------------
  // Pending register
  // -------------------------------------------------------------------------
  // The attend is taken only in REQ. It clears the pending bit of the vector
  // being serviced.
  assign attend_take   = (state_q == REQ) && int_ack_attended;
  assign number_onehot = NUM_SRC'(1) << int_number_q;

  // The set term is ORed in last, so a new edge on the same clock as the
  // attend clear leaves the bit pending.
  always_comb begin
    pending_d = pending_q;
    if (attend_take) pending_d = pending_d & ~number_onehot;
    pending_d = pending_d | rise;
  end

  // Latch edges into pending. The mask does not gate this register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  // -------------------------------------------------------------------------
  // Priority select: lowest eligible index wins
  // -------------------------------------------------------------------------
  assign eligible = pending_q & mask_q;

  // Scan from the highest index down, so the lowest set bit is written last.
  always_comb begin
    // NOTE: both outputs get a default before the loop. Without one, a path
    // that leaves them unassigned would infer a latch.
    winner_valid = 1'b0;
    winner_idx   = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner_valid = 1'b1;
        winner_idx   = 2'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Handshake FSM with registered outputs
  // -------------------------------------------------------------------------
  // IDLE picks a winner, REQ holds the vector until attend, and SERVICE waits
  // for complete. The vector stays frozen from the IDLE decision until the
  // next IDLE decision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      int_req_q    <= 1'b0;
      int_number_q <= 2'd0;
      in_service_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (winner_valid) begin
            state_q      <= REQ;
            int_req_q    <= 1'b1;
            int_number_q <= winner_idx;
          end
        end
        REQ: begin
          // Attend wins over a same-cycle complete. Complete is ignored here.
          if (int_ack_attended) begin
            state_q      <= SERVICE;
            int_req_q    <= 1'b0;
            in_service_q <= number_onehot;
          end
        end
        SERVICE: begin
          if (int_ack_complete) begin
            state_q      <= IDLE;
            in_service_q <= '0;
          end
        end
        default: begin
          state_q      <= IDLE;
          int_req_q    <= 1'b0;
          in_service_q <= '0;
        end
      endcase
    end
  end

  assign int_req    = int_req_q;
  assign int_number = int_number_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_vespa_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vespa_int_ctrl
// Directed testbench for vespa_int_ctrl. Expected values are computed by
// hand. Inputs change 1 time unit after the rising edge, and outputs are
// sampled at the same point.
// ---------------------------------------------------------------------------
module tb_vespa_int_ctrl;

`ifdef INT_CTRL_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_data;
  logic       int_req;
  logic [1:0] int_number;
  logic       int_ack_attended;
  logic       int_ack_complete;
  logic [3:0] pending;
  logic [3:0] in_service;

  int total;
  int bad;

  vespa_int_ctrl #(.NUM_SRC(4), .RST_MASK(4'b0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .irq_in           (irq_in),
    .mask_we          (mask_we),
    .mask_data        (mask_data),
    .int_req          (int_req),
    .int_number       (int_number),
    .int_ack_attended (int_ack_attended),
    .int_ack_complete (int_ack_complete),
    .pending          (pending),
    .in_service       (in_service)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge, then step 1 unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    irq_in = 4'b0000; mask_we = 1'b0; mask_data = 4'b0000;
    int_ack_attended = 1'b0; int_ack_complete = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_data = m; mask_we = 1'b1;
    tick();
    mask_we = 1'b0;
  endtask

  // Drive a one-cycle pulse on irq_in, then wait until the edge reaches
  // pending. int_req has not risen yet on return.
  task automatic pulse_irq(input logic [3:0] v);
    irq_in = v;
    tick();
    irq_in = 4'b0000;
    repeat (SYNC_DLY) tick();
  endtask

  task automatic pulse_attend();
    int_ack_attended = 1'b1;
    tick();
    int_ack_attended = 1'b0;
  endtask

  task automatic pulse_complete();
    int_ack_complete = 1'b1;
    tick();
    int_ack_complete = 1'b0;
  endtask

  task automatic test_reset();
    irq_in = 4'b0000; mask_we = 1'b0; mask_data = 4'b0000;
    int_ack_attended = 1'b0; int_ack_complete = 1'b0;
    rst = 1'b0;
    #3;
    if (int_req !== 1'b0) begin bad++; $display("FAIL reset_int_req got=%b exp=0", int_req); end
    total++;
    if (int_number !== 2'd0) begin bad++; $display("FAIL reset_int_number got=%0d exp=0", int_number); end
    total++;
    if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    total++;
    if (in_service !== 4'b0000) begin bad++; $display("FAIL reset_in_service got=%b exp=0000", in_service); end
    total++;
    tick();
    rst = 1'b1;
    tick();
    // The reset mask is 0000, so an edge latches but is never requested.
    pulse_irq(4'b1000);
    if (pending !== 4'b1000) begin bad++; $display("FAIL reset_mask_pending got=%b exp=1000", pending); end
    total++;
    repeat (5) tick();
    if (int_req !== 1'b0) begin bad++; $display("FAIL reset_mask_no_req got=%b exp=0", int_req); end
    total++;
  endtask

  task automatic test_basic();
    do_reset();
    write_mask(4'b1111);
    pulse_irq(4'b0100);
    if (pending !== 4'b0100) begin bad++; $display("FAIL basic_pending got=%b exp=0100", pending); end
    total++;
    if (int_req !== 1'b0) begin bad++; $display("FAIL basic_req_early got=%b exp=0", int_req); end
    total++;
    tick();
    if (int_req !== 1'b1 || int_number !== 2'd2) begin
      bad++; $display("FAIL basic_req got=%b/%0d exp=1/2", int_req, int_number);
    end
    total++;
    pulse_attend();
    if (pending !== 4'b0000 || in_service !== 4'b0100 || int_req !== 1'b0) begin
      bad++; $display("FAIL basic_attend got pend=%b insv=%b req=%b exp 0000/0100/0", pending, in_service, int_req);
    end
    total++;
    pulse_complete();
    if (in_service !== 4'b0000 || int_req !== 1'b0) begin
      bad++; $display("FAIL basic_complete got insv=%b req=%b exp 0000/0", in_service, int_req);
    end
    total++;
  endtask

  task automatic test_priority();
    do_reset();
    write_mask(4'b1111);
    pulse_irq(4'b1010);
    tick();
    if (int_req !== 1'b1 || int_number !== 2'd1) begin
      bad++; $display("FAIL prio_first got=%b/%0d exp=1/1", int_req, int_number);
    end
    total++;
    pulse_attend();
    if (pending !== 4'b1000 || in_service !== 4'b0010) begin
      bad++; $display("FAIL prio_attend got pend=%b insv=%b exp 1000/0010", pending, in_service);
    end
    total++;
    pulse_complete();
    if (int_req !== 1'b0) begin bad++; $display("FAIL prio_gap got=%b exp=0", int_req); end
    total++;
    tick();
    if (int_req !== 1'b1 || int_number !== 2'd3) begin
      bad++; $display("FAIL prio_second got=%b/%0d exp=1/3", int_req, int_number);
    end
    total++;
  endtask

  task automatic test_mask();
    bit held_low;
    do_reset();
    write_mask(4'b1110);
    pulse_irq(4'b0001);
    if (pending !== 4'b0001) begin bad++; $display("FAIL mask_pending got=%b exp=0001", pending); end
    total++;
    held_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (int_req !== 1'b0) held_low = 1'b0;
    end
    if (!held_low) begin bad++; $display("FAIL mask_hold got=raised exp=low_for_20"); end
    total++;
    // The decision on the mask-write edge still uses the old mask.
    write_mask(4'b1111);
    if (int_req !== 1'b0) begin bad++; $display("FAIL mask_old_used got=%b exp=0", int_req); end
    total++;
    tick();
    if (int_req !== 1'b1 || int_number !== 2'd0) begin
      bad++; $display("FAIL mask_unmask got=%b/%0d exp=1/0", int_req, int_number);
    end
    total++;
  endtask

  task automatic test_service();
    do_reset();
    write_mask(4'b1111);
    pulse_irq(4'b0100);
    tick();
    pulse_attend();
    pulse_irq(4'b0001);
    if (pending !== 4'b0001) begin bad++; $display("FAIL svc_pending got=%b exp=0001", pending); end
    total++;
    // An attend in SERVICE is ignored.
    pulse_attend();
    repeat (4) tick();
    if (int_req !== 1'b0 || int_number !== 2'd2 || in_service !== 4'b0100 || pending !== 4'b0001) begin
      bad++; $display("FAIL svc_hold got req=%b num=%0d insv=%b pend=%b exp 0/2/0100/0001",
                      int_req, int_number, in_service, pending);
    end
    total++;
    pulse_complete();
    tick();
    if (int_req !== 1'b1 || int_number !== 2'd0) begin
      bad++; $display("FAIL svc_next got=%b/%0d exp=1/0", int_req, int_number);
    end
    total++;
    // A complete in REQ is ignored.
    pulse_complete();
    if (int_req !== 1'b1 || int_number !== 2'd0 || in_service !== 4'b0000) begin
      bad++; $display("FAIL svc_cpl_in_req got req=%b num=%0d insv=%b exp 1/0/0000", int_req, int_number, in_service);
    end
    total++;
    // Attend and complete together in REQ: the attend is taken.
    int_ack_attended = 1'b1; int_ack_complete = 1'b1;
    tick();
    int_ack_attended = 1'b0; int_ack_complete = 1'b0;
    if (in_service !== 4'b0001 || int_req !== 1'b0) begin
      bad++; $display("FAIL svc_both got insv=%b req=%b exp 0001/0", in_service, int_req);
    end
    total++;
    pulse_complete();
    // A complete in IDLE is ignored.
    pulse_complete();
    tick();
    if (int_req !== 1'b0 || in_service !== 4'b0000 || pending !== 4'b0000 || int_number !== 2'd0) begin
      bad++; $display("FAIL svc_cpl_idle got req=%b insv=%b pend=%b num=%0d exp 0/0000/0000/0",
                      int_req, in_service, pending, int_number);
    end
    total++;
  endtask

  task automatic test_attend_collision();
    do_reset();
    write_mask(4'b1111);
    pulse_irq(4'b0010);
    tick();
    // Time a second edge on source 1 to reach edge detection on the attend edge.
    irq_in = 4'b0010;
    if (SYNC_DLY > 0) begin
      tick();
      irq_in = 4'b0000;
      repeat (SYNC_DLY - 1) tick();
    end
    int_ack_attended = 1'b1;
    tick();
    int_ack_attended = 1'b0;
    irq_in = 4'b0000;
    if (pending !== 4'b0010 || in_service !== 4'b0010 || int_req !== 1'b0) begin
      bad++; $display("FAIL coll_attend got pend=%b insv=%b req=%b exp 0010/0010/0", pending, in_service, int_req);
    end
    total++;
    pulse_complete();
    tick();
    if (int_req !== 1'b1 || int_number !== 2'd1) begin
      bad++; $display("FAIL coll_rereq got=%b/%0d exp=1/1", int_req, int_number);
    end
    total++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_mask(4'b1111);
    pulse_irq(4'b1001);
    tick();
    #2;
    rst = 1'b0;
    #1;
    // Sampled before the next rising edge, so the reset acts asynchronously.
    if (int_req !== 1'b0 || pending !== 4'b0000 || in_service !== 4'b0000) begin
      bad++; $display("FAIL rst_mid got req=%b pend=%b insv=%b exp 0/0000/0000", int_req, pending, in_service);
    end
    total++;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    int n;
    do_reset();
    write_mask(4'b1111);
    irq_in = 4'b0001;
    n = 0;
    while (n < 12 && int_req !== 1'b1) begin
      tick();
      n++;
      irq_in = 4'b0000;
    end
    if (n !== SYNC_DLY + 2 || int_req !== 1'b1) begin
      bad++; $display("FAIL latency got=%0d clocks exp=%0d", n, SYNC_DLY + 2);
    end
    total++;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_service();
    test_attend_collision();
    test_reset_mid();
    test_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
